// File: rtl/phs_pkg.sv
// Shared definitions for the pulse handshake sender: FSM state encoding and
// default parameter values.
package phs_pkg;

    typedef enum logic [1:0] {
        PHS_IDLE    = 2'd0,
        PHS_REQ     = 2'd1,
        PHS_RELEASE = 2'd2
    } phs_state_e;

    localparam int PHS_CNT_W_DEF       = 4;
    localparam int PHS_SYNC_STAGES_DEF = 2;
    localparam int PHS_TIMEOUT_W_DEF   = 8;

endpackage

// File: rtl/sync_chain.sv
// N-flop synchronizer for a single asynchronous input, cleared asynchronously
// by an active-low reset. The output is the last flop of the chain.
module sync_chain #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/pulse_handshake_sender.sv
// Source end of the cross-clock event path: counts event pulses and sends each
// as a four-phase req/ack handshake. Define PHS_TIMEOUT_EN to abandon stalled handshakes.
module pulse_handshake_sender
    import phs_pkg::*;
#(
    parameter int CNT_W       = PHS_CNT_W_DEF,
    parameter int SYNC_STAGES = PHS_SYNC_STAGES_DEF,
    parameter int TIMEOUT_W   = PHS_TIMEOUT_W_DEF
) (
    input  logic             inclk,
    input  logic             reset_n,
    input  logic             event_in,
    input  logic             ack_in,
    input  logic             clear_ovf,
    output logic             req_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
`ifdef PHS_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    generate
        if (SYNC_STAGES < 2 || TIMEOUT_W < 1 || CNT_W < 1) begin : g_param_check
            $error("pulse_handshake_sender: illegal parameter value");
        end
    endgenerate

    logic             ack_s;
    phs_state_e       state_q;
    logic             req_q;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             ovf_q, ovf_d;
    logic             launch;

    sync_chain #(
        .N(SYNC_STAGES)
    ) u_ack_sync (
        .clk_i (inclk),
        .rst_ni(reset_n),
        .d_i   (ack_in),
        .q_o   (ack_s)
    );

    assign launch = (state_q == PHS_IDLE) && (pending_q != '0);

    // A set caused by a dropped event overrides a simultaneous clear.
    always_comb begin
        pending_d = pending_q;
        ovf_d     = ovf_q;
        if (clear_ovf) begin
            ovf_d = 1'b0;
        end
        if (event_in && !launch) begin
            if (pending_q == '1) begin
                ovf_d = 1'b1;
            end else begin
                pending_d = pending_q + CNT_W'(1);
            end
        end else if (launch && !event_in) begin
            pending_d = pending_q - CNT_W'(1);
        end
    end

`ifdef PHS_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] timer_q;
    logic                 timeout_q;
`endif

    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= PHS_IDLE;
            req_q     <= 1'b0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
`ifdef PHS_TIMEOUT_EN
            timer_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            case (state_q)
                PHS_IDLE: begin
                    if (launch) begin
                        state_q <= PHS_REQ;
                        req_q   <= 1'b1;
                    end
                end
                PHS_REQ: begin
                    if (ack_s) begin
                        state_q <= PHS_RELEASE;
                        req_q   <= 1'b0;
                    end
                end
                PHS_RELEASE: begin
                    if (!ack_s) begin
                        state_q <= PHS_IDLE;
                    end
                end
                default: begin
                    state_q <= PHS_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
`ifdef PHS_TIMEOUT_EN
            // Written after the case so an expired timer overrides any transition.
            timeout_q <= 1'b0;
            if (state_q == PHS_IDLE) begin
                timer_q <= '0;
            end else if (timer_q == '1) begin
                state_q   <= PHS_IDLE;
                req_q     <= 1'b0;
                timeout_q <= 1'b1;
                timer_q   <= '0;
            end else if ((state_q == PHS_REQ && ack_s) ||
                         (state_q == PHS_RELEASE && !ack_s)) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TIMEOUT_W'(1);
            end
`endif
        end
    end

    assign req_out  = req_q;
    assign pending  = pending_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != PHS_IDLE) || (pending_q != '0);
`ifdef PHS_TIMEOUT_EN
    assign timeout  = timeout_q;
`endif

endmodule
